// File: rtl/axis_dest_demux_pkg.sv
// Shared types and helpers for tdest-routed AXI-Stream blocks.
package axis_dest_demux_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFwd  = 2'd1,
    StDrop = 2'd2
  } demux_state_e;

  localparam int unsigned DropCountWidth = 16;

  // Inclusive range match of a destination against one port's window.
  function automatic logic dest_in_range(input int unsigned dest, input int unsigned base,
                                         input int unsigned top);
    return (dest >= base) && (dest <= top);
  endfunction

endpackage

// File: rtl/axis_demux_out_slot.sv
// One-beat output holding register: loads a packed beat, holds it until the consumer takes it.
module axis_demux_out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] beat_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] beat_out,
  output logic             free
);

  logic             valid_q;
  logic [WIDTH-1:0] beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      beat_q <= beat_in;
    end
  end

  assign valid    = valid_q;
  assign beat_out = beat_q;
  assign free     = !valid_q || ready;

endmodule

// File: rtl/axis_dest_demux.sv
// AXI-Stream demultiplexer routing whole frames by the tdest of their first beat.
module axis_dest_demux
  import axis_dest_demux_pkg::*;
#(
  parameter int unsigned                  M_COUNT     = 4,
  parameter int unsigned                  DATA_WIDTH  = 8,
  parameter bit                           KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned                  KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit                           ID_ENABLE   = 1'b1,
  parameter int unsigned                  ID_WIDTH    = 8,
  parameter int unsigned                  DEST_WIDTH  = $clog2(M_COUNT + 1),
  parameter bit                           USER_ENABLE = 1'b1,
  parameter int unsigned                  USER_WIDTH  = 1,
  parameter logic [M_COUNT*DEST_WIDTH-1:0] M_BASE     = '0,
  parameter logic [M_COUNT*DEST_WIDTH-1:0] M_TOP      = '0,
  parameter logic [M_COUNT-1:0]            M_ENABLE   = {M_COUNT{1'b1}}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [ID_WIDTH-1:0]            s_axis_tid,
  input  logic [DEST_WIDTH-1:0]          s_axis_tdest,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [M_COUNT-1:0]             m_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_axis_tready,
  output logic [M_COUNT-1:0]             m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]    m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]  m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser,
  output logic                           drop_frame,
  output logic [DropCountWidth-1:0]      drop_count
);

  localparam int unsigned SelWidth  = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int unsigned KeepOff   = DATA_WIDTH;
  localparam int unsigned IdOff     = KeepOff + KEEP_WIDTH;
  localparam int unsigned DestOff   = IdOff + ID_WIDTH;
  localparam int unsigned UserOff   = DestOff + DEST_WIDTH;
  localparam int unsigned LastOff   = UserOff + USER_WIDTH;
  localparam int unsigned BeatWidth = LastOff + 1;

  // A zero base vector means each port answers to its own index.
  function automatic int unsigned port_base(input int unsigned k);
    int unsigned v;
    v = k;
    if (M_BASE != '0) begin
      v = '0;
      v[DEST_WIDTH-1:0] = M_BASE[k*DEST_WIDTH +: DEST_WIDTH];
    end
    return v;
  endfunction

  function automatic int unsigned port_top(input int unsigned k);
    int unsigned v;
    v = port_base(k);
    if (M_TOP != '0) begin
      v = '0;
      v[DEST_WIDTH-1:0] = M_TOP[k*DEST_WIDTH +: DEST_WIDTH];
    end
    return v;
  endfunction

  demux_state_e                state_q;
  logic [SelWidth-1:0]         sel_q;
  logic                        drop_frame_q;
  logic [DropCountWidth-1:0]   drop_count_q;

  logic                        match_found;
  logic [SelWidth-1:0]         match_idx;
  int unsigned                 dest_ext;
  logic [M_COUNT-1:0]          slot_free;
  logic [M_COUNT-1:0]          slot_load;
  logic                        s_ready;
  logic                        accept;
  logic                        fwd_beat;
  logic                        drop_done;
  logic [SelWidth-1:0]         target;
  logic [BeatWidth-1:0]        s_beat;

  assign s_beat = {s_axis_tlast, s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tkeep,
                   s_axis_tdata};

  // Descending scan so the lowest-index matching port is the final winner.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    dest_ext    = '0;
    dest_ext[DEST_WIDTH-1:0] = s_axis_tdest;
    for (int k = M_COUNT - 1; k >= 0; k--) begin
      if (M_ENABLE[k] && dest_in_range(dest_ext, port_base(k), port_top(k))) begin
        match_found = 1'b1;
        match_idx   = SelWidth'(k);
      end
    end
  end

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      StIdle:  s_ready = s_axis_tvalid && (match_found ? slot_free[match_idx] : 1'b1);
      StFwd:   s_ready = slot_free[sel_q];
      StDrop:  s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
    accept    = s_axis_tvalid && s_ready;
    target    = (state_q == StIdle) ? match_idx : sel_q;
    fwd_beat  = accept && ((state_q == StFwd) || ((state_q == StIdle) && match_found));
    drop_done = accept && s_axis_tlast &&
                ((state_q == StDrop) || ((state_q == StIdle) && !match_found));
    for (int k = 0; k < M_COUNT; k++) begin
      slot_load[k] = fwd_beat && (target == SelWidth'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      drop_frame_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      drop_frame_q <= drop_done;
      if (drop_done && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (accept && !s_axis_tlast) begin
            state_q <= match_found ? StFwd : StDrop;
          end
          if (accept && match_found) begin
            sel_q <= match_idx;
          end
        end
        StFwd, StDrop: begin
          if (accept && s_axis_tlast) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < M_COUNT; k++) begin : g_slot
    logic [BeatWidth-1:0] beat;

    axis_demux_out_slot #(
      .WIDTH(BeatWidth)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (slot_load[k]),
      .beat_in (s_beat),
      .ready   (m_axis_tready[k]),
      .valid   (m_axis_tvalid[k]),
      .beat_out(beat),
      .free    (slot_free[k])
    );

    assign m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] = beat[DATA_WIDTH-1:0];
    assign m_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH] =
        KEEP_ENABLE ? beat[KeepOff +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
    assign m_axis_tid[k*ID_WIDTH +: ID_WIDTH] = ID_ENABLE ? beat[IdOff +: ID_WIDTH] : '0;
    assign m_axis_tdest[k*DEST_WIDTH +: DEST_WIDTH] = beat[DestOff +: DEST_WIDTH];
    assign m_axis_tuser[k*USER_WIDTH +: USER_WIDTH] =
        USER_ENABLE ? beat[UserOff +: USER_WIDTH] : '0;
    assign m_axis_tlast[k] = beat[LastOff];
  end

  assign s_axis_tready = s_ready;
  assign drop_frame    = drop_frame_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_axis_dest_demux.sv
// Bench for axis_dest_demux: per-port expected-beat queues driven by a frame-level routing model.
module tb_axis_dest_demux;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic [0:0]  s_axis_tkeep = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tid = '0;
  logic [2:0]  s_axis_tdest = '0;
  logic [0:0]  s_axis_tuser = '0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic [3:0]  m_axis_tvalid;
  logic [3:0]  m_axis_tready = '1;
  logic [3:0]  m_axis_tlast;
  logic [31:0] m_axis_tid;
  logic [11:0] m_axis_tdest;
  logic [3:0]  m_axis_tuser;
  logic        drop_frame;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  axis_dest_demux dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tid   (s_axis_tid),
    .s_axis_tdest (s_axis_tdest),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tuser (m_axis_tuser),
    .drop_frame   (drop_frame),
    .drop_count   (drop_count)
  );

  typedef struct packed {
    logic       last;
    logic       user;
    logic [2:0] dest;
    logic [7:0] id;
    logic [7:0] data;
  } beat_t;

  // Reference model: beats each port still owes its consumer, plus open-frame routing.
  beat_t exp_q [M][$];
  bit    in_frame;
  int    cur_tgt;
  bit    exp_drop;
  int    exp_cnt;
  int    n_checks;
  int    n_fail;

  task automatic model_reset();
    for (int k = 0; k < M; k++) exp_q[k].delete();
    in_frame = 1'b0;
    cur_tgt  = 0;
    exp_drop = 1'b0;
    exp_cnt  = 0;
  endtask

  // One clock cycle: drive, check everything against the model, then advance the model.
  task automatic cycle(input logic v, input logic [2:0] d, input logic l, input logic [3:0] rdy,
                       output bit accepted);
    beat_t b;
    beat_t e;
    beat_t got;
    int    t;
    logic  exp_rdy;
    logic  ev;
    @(negedge clk);
    b.data = 8'($urandom);
    b.id   = 8'($urandom);
    b.user = 1'($urandom);
    b.dest = d;
    b.last = l;
    s_axis_tvalid = v;
    s_axis_tdata  = b.data;
    s_axis_tid    = b.id;
    s_axis_tuser  = b.user;
    s_axis_tdest  = d;
    s_axis_tlast  = l;
    s_axis_tkeep  = 1'($urandom);
    m_axis_tready = rdy;
    #1;
    if (in_frame) t = cur_tgt;
    else t = (int'(d) < M) ? int'(d) : -1;
    if (!in_frame && !v) exp_rdy = 1'b0;
    else if (t < 0) exp_rdy = 1'b1;
    else exp_rdy = (exp_q[t].size() == 0) || rdy[t];
    n_checks++;
    if (s_axis_tready !== exp_rdy) begin
      n_fail++;
      $display("FAIL s_tready: got %b expected %b at %0t", s_axis_tready, exp_rdy, $time);
    end
    for (int k = 0; k < M; k++) begin
      ev = (exp_q[k].size() != 0);
      n_checks++;
      if (m_axis_tvalid[k] !== ev) begin
        n_fail++;
        $display("FAIL m_tvalid port%0d: got %b expected %b at %0t", k, m_axis_tvalid[k], ev,
                 $time);
      end
      if (ev) begin
        e   = exp_q[k][0];
        got = {m_axis_tlast[k], m_axis_tuser[k], m_axis_tdest[k*3 +: 3], m_axis_tid[k*8 +: 8],
               m_axis_tdata[k*8 +: 8]};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL m_beat port%0d: got %h expected %h at %0t", k, got, e, $time);
        end
        n_checks++;
        if (m_axis_tkeep[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL m_tkeep port%0d: got %b expected 1", k, m_axis_tkeep[k]);
        end
      end
    end
    n_checks++;
    if (drop_frame !== exp_drop) begin
      n_fail++;
      $display("FAIL drop_frame: got %b expected %b at %0t", drop_frame, exp_drop, $time);
    end
    n_checks++;
    if (drop_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL drop_count: got %0d expected %0d at %0t", drop_count, exp_cnt, $time);
    end
    for (int k = 0; k < M; k++) begin
      if (exp_q[k].size() != 0 && rdy[k]) void'(exp_q[k].pop_front());
    end
    accepted = v && exp_rdy;
    exp_drop = 1'b0;
    if (accepted) begin
      if (t >= 0) exp_q[t].push_back(b);
      if (l) begin
        in_frame = 1'b0;
        if (t < 0) begin
          exp_drop = 1'b1;
          if (exp_cnt < 65535) exp_cnt++;
        end
      end else begin
        in_frame = 1'b1;
        cur_tgt  = t;
      end
    end
  endtask

  task automatic idle(input int n, input logic [3:0] rdy);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, rdy, a);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = '1;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset m_tvalid: got %b expected 0000", m_axis_tvalid);
    end
    n_checks++;
    if (s_axis_tready !== 1'b0 || drop_frame !== 1'b0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got rdy=%b drop=%b cnt=%0d expected 0/0/0", s_axis_tready,
               drop_frame, drop_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    idle(2, 4'hF);
  endtask

  task automatic test_basic();
    bit a;
    cycle(1'b1, 3'd2, 1'b0, 4'hF, a);
    cycle(1'b1, 3'd2, 1'b0, 4'hF, a);
    cycle(1'b1, 3'd2, 1'b1, 4'hF, a);
    idle(2, 4'hF);
  endtask

  task automatic test_back_to_back();
    bit a;
    cycle(1'b1, 3'd1, 1'b0, 4'hF, a);
    cycle(1'b1, 3'd1, 1'b1, 4'hF, a);
    cycle(1'b1, 3'd3, 1'b0, 4'b1101, a);
    cycle(1'b1, 3'd3, 1'b0, 4'b1101, a);
    cycle(1'b1, 3'd3, 1'b1, 4'b1101, a);
    idle(2, 4'b1101);
    idle(2, 4'hF);
  endtask

  task automatic test_drop();
    bit a;
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'd5, (i == 3), 4'hF, a);
    idle(2, 4'hF);
  endtask

  task automatic test_toggle();
    bit a;
    int sent = 0;
    int tries = 0;
    logic r2 = 1'b1;
    while (sent < 8 && tries < 40) begin
      cycle(1'b1, 3'd2, (sent == 7), {1'b1, r2, 2'b11}, a);
      if (a) sent++;
      r2 = ~r2;
      tries++;
    end
    n_checks++;
    if (sent != 8) begin
      n_fail++;
      $display("FAIL toggle_progress: got %0d beats accepted expected 8", sent);
    end
    idle(2, 4'hF);
  endtask

  task automatic test_reset_mid_frame();
    bit a;
    cycle(1'b1, 3'd0, 1'b0, 4'hF, a);
    cycle(1'b1, 3'd0, 1'b0, 4'hF, a);
    apply_reset();
    cycle(1'b1, 3'd1, 1'b0, 4'hF, a);
    cycle(1'b1, 3'd1, 1'b1, 4'hF, a);
    idle(2, 4'hF);
  endtask

  task automatic test_random();
    bit a;
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
            4'($urandom), a);
    end
    // Close any open frame, then drain every port.
    for (int i = 0; i < 20 && in_frame; i++) cycle(1'b1, 3'd0, 1'b1, 4'hF, a);
    idle(3, 4'hF);
  endtask

  task automatic test_saturate();
    bit a;
    apply_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdest  = 3'd7;
    s_axis_tlast  = 1'b1;
    m_axis_tready = '1;
    repeat (65534) @(negedge clk);
    s_axis_tvalid = 1'b0;
    exp_cnt  = 65534;
    exp_drop = 1'b0;
    idle(1, 4'hF);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd6, 1'b1, 4'hF, a);
    idle(2, 4'hF);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_toggle();
    test_reset_mid_frame();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
